// File: rtl/operand_hazard_unit.sv
// rtl/operand_hazard_unit.sv - operand forwarding selects and load-use stall for operand fetch
//
// Purpose:
//   Tracks the destination tags of the instructions in OF and EX and produces
//   registered forwarding selects for the operand-fetch muxes, plus a
//   combinational load-use stall for decode. A two-state FSM (RUN/BUBBLE)
//   ensures a load-use hazard stalls exactly once.
//
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   AA, BA, MA, MB      decode source addresses and constant-operand selects
//   DA, RW, MD          decode destination, write enable, load indicator
//   Flush               kill the instruction entering OF
//   EX_Hazard_A/B       OF operand takes the EX-stage forward bus
//   WB_Hazard_A/B       OF operand takes the WB-stage BUS_D
//   Stall               hold PC and decode register this cycle
//   Fwd_Count           (HAZARD_STATS_EN) edges that set any hazard flag, saturating
//   Stall_Count         (HAZARD_STATS_EN) cycles with Stall=1, saturating
//
// Optional feature macro: HAZARD_STATS_EN
module operand_hazard_unit #(
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] AA,
  input  logic [AW-1:0] BA,
  input  logic          MA,
  input  logic          MB,
  input  logic [AW-1:0] DA,
  input  logic          RW,
  input  logic          MD,
  input  logic          Flush,
  output logic          EX_Hazard_A,
  output logic          WB_Hazard_A,
  output logic          EX_Hazard_B,
  output logic          WB_Hazard_B,
  output logic          Stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]   Fwd_Count,
  output logic [15:0]   Stall_Count
`endif
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t state, state_next;

  // OF and EX tags. The WB-stage tag and the EX load bit are not stored:
  // no output ever compares against them, since a producer in WB is
  // already visible to the register file by the time a consumer reads it.
  logic [AW-1:0] da_of, da_ex;
  logic          rw_of, rw_ex;
  logic          md_of;

  logic hit_a_of, hit_b_of, hit_a_ex, hit_b_ex;
  logic lu;

  function automatic logic match(input logic [AW-1:0] src,
                                 input logic [AW-1:0] tag_da,
                                 input logic          tag_rw);
    return tag_rw && (tag_da == src) && !(ZERO_REG && (src == '0));
  endfunction

  always_comb begin
    hit_a_of = !MA && match(AA, da_of, rw_of);
    hit_b_of = !MB && match(BA, da_of, rw_of);
    hit_a_ex = !MA && match(AA, da_ex, rw_ex);
    hit_b_ex = !MB && match(BA, da_ex, rw_ex);
    lu       = md_of && rw_of && (hit_a_of || hit_b_of);
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic; Flush wins over load-use.
  always_comb begin
    state_next = RUN;
    case (state)
      RUN:     state_next = (lu && !Flush) ? BUBBLE : RUN;
      BUBBLE:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic: stall only from RUN, so one load stalls at most once.
  always_comb begin
    Stall = 1'b0;
    if (state == RUN && lu && !Flush) Stall = 1'b1;
  end

  // Tag pipeline and registered forwarding flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      da_of       <= '0;
      rw_of       <= 1'b0;
      md_of       <= 1'b0;
      da_ex       <= '0;
      rw_ex       <= 1'b0;
      EX_Hazard_A <= 1'b0;
      WB_Hazard_A <= 1'b0;
      EX_Hazard_B <= 1'b0;
      WB_Hazard_B <= 1'b0;
    end else begin
      da_ex <= da_of;
      rw_ex <= rw_of;
      if (Stall) begin
        // Bubble enters OF; decode re-presents the held instruction next cycle.
        da_of       <= '0;
        rw_of       <= 1'b0;
        md_of       <= 1'b0;
        EX_Hazard_A <= 1'b0;
        WB_Hazard_A <= 1'b0;
        EX_Hazard_B <= 1'b0;
        WB_Hazard_B <= 1'b0;
      end else begin
        da_of       <= DA;
        rw_of       <= RW && !Flush;
        md_of       <= MD;
        EX_Hazard_A <= hit_a_of;
        WB_Hazard_A <= hit_a_ex;
        EX_Hazard_B <= hit_b_of;
        WB_Hazard_B <= hit_b_ex;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic any_set;
  assign any_set = !Stall && (hit_a_of || hit_b_of || hit_a_ex || hit_b_ex);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Fwd_Count   <= '0;
      Stall_Count <= '0;
    end else begin
      if (any_set && Fwd_Count != 16'hFFFF)  Fwd_Count   <= Fwd_Count + 16'd1;
      if (Stall && Stall_Count != 16'hFFFF)  Stall_Count <= Stall_Count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/operand_hazard_unit.md
Name: operand_hazard_unit

Overview:
- Tracks destination tags of in-flight instructions and generates the forwarding selects (EX_Hazard_A/B, WB_Hazard_A/B) consumed by the operand-fetch muxes (MUX_A / MUX_B), plus the load-use stall for decode.
- Sits beside decode. It samples decoded register fields each time an instruction advances into operand fetch (OF).
- It keeps a two-deep tag pipeline (EX, WB), so its registered outputs are valid throughout the OF cycle of that instruction.

Parameters:
- AW, 5, register address width
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never forwarded; 0 = register 0 is an ordinary register

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- AA  input  AW  decode: source A address
- BA  input  AW  decode: source B address
- MA  input  1  decode: 1 = A operand is PC/constant (no A hazard)
- MB  input  1  decode: 1 = B operand is constant (no B hazard)
- DA  input  AW  decode: destination address
- RW  input  1  decode: register write enable
- MD  input  1  decode: result comes from memory (load)
- Flush  input  1  branch taken: kill instruction entering OF
- EX_Hazard_A  output  1  OF operand A takes EX-stage Forward bus
- WB_Hazard_A  output  1  OF operand A takes WB-stage BUS_D
- EX_Hazard_B  output  1  OF operand B takes EX-stage Forward bus
- WB_Hazard_B  output  1  OF operand B takes WB-stage BUS_D
- Stall  output  1  hold PC and decode register this cycle (combinational)

Behaviour:
- Internal tags:
  - OF tag {DA_OF, RW_OF, MD_OF}
  - EX tag {DA_EX, RW_EX, MD_EX}
  - WB tag {DA_WB, RW_WB}
- Reset clears all tags and all four hazard outputs, and puts the FSM in RUN.
- Match(src, tag): tag.RW=1 and tag.DA=src, and not (ZERO_REG=1 and src=0).
- Each rising edge when not stalling:
  - WB tag <= EX tag.
  - EX tag <= OF tag.
  - OF tag <= decode fields, with RW forced to 0 if Flush=1.
  - EX_Hazard_A <= !MA & Match(AA, OF tag).
  - WB_Hazard_A <= !MA & Match(AA, EX tag).
  - The B flags follow the same rules with BA and MB.
  - Both flags may be 1 together. The consumer gives EX priority; this unit reports both raw.
- Load-use: LU = MD_OF & RW_OF & ((!MA & Match(AA, OF tag)) | (!MB & Match(BA, OF tag))).
- FSM states: RUN, BUBBLE.
- RUN:
  - If LU=1 and Flush=0: Stall=1 and next state is BUBBLE.
  - Edge action for that LU cycle: tags still shift. The OF tag takes a bubble (RW=0, MD=0), and the hazard flags are cleared.
- BUBBLE:
  - Stall=0.
  - Decode re-presents the held instruction. Its comparison now hits the EX tag (the load), so the normal WB forward is produced next cycle.
  - Next state is RUN.
- Stall is 0 in BUBBLE state, so two stalls are never issued back to back for the same load.
- Flush has priority over LU. With Flush=1:
  - Stall=0.
  - The OF tag is killed.
  - The FSM returns to RUN.
- Asynchronous RESET mid-operation (including in BUBBLE) returns immediately to the reset state. Stall drops the same cycle.
- Latency:
  - Flags are registered, 1 cycle after decode presents fields.
  - Stall is combinational from the current OF tag and the decode inputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds 16-bit outputs Fwd_Count and Stall_Count.
  - Fwd_Count increments on each edge that sets any hazard flag, by 1 per edge regardless of how many flags are set.
  - Stall_Count increments on each cycle with Stall=1.
  - Both saturate at 16'hFFFF and clear on RESET.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Back-to-back ALU ops:
  - Stimulus: instruction 1 writes R3 (RW=1, MD=0); next instruction reads BA=3, MB=0.
  - Required response: EX_Hazard_B=1, WB_Hazard_B=0 during its OF cycle; Stall never asserted.
- Distance-two dependency:
  - Stimulus: write R5, one independent instruction, then read AA=5.
  - Required response: WB_Hazard_A=1, EX_Hazard_A=0.
- Double hit:
  - Stimulus: write R7, write R7 again, then read BA=7.
  - Required response: EX_Hazard_B=1 and WB_Hazard_B=1 together.
- Constant operand:
  - Stimulus: write R2, then BA=2 with MB=1.
  - Required response: EX_Hazard_B=0 and WB_Hazard_B=0.
- R0 handling:
  - Stimulus: with ZERO_REG=1, write R0 then read R0.
  - Required response: all flags 0.
- Load-use:
  - Stimulus: load R4 (MD=1), then read AA=4.
  - Required response: Stall=1 for exactly 1 cycle, then one bubble, then WB_Hazard_A=1 on the re-presented read.
  - With HAZARD_STATS_EN defined: Stall_Count=1.
- Flush during stall:
  - Stimulus: the load-use case above, with Flush=1 in the LU cycle.
  - Required response: Stall=0 and the FSM stays in RUN.
- Reset in BUBBLE:
  - Stimulus: assert RESET while the FSM is in BUBBLE.
  - Required response: all outputs 0 immediately.
